// File: rtl/lab1_sys_clkgen_pkg.sv
// Shared definitions for the reference clock generator: FSM encoding,
// channel reset defaults and the supported channel count.
package lab1_sys_clkgen_pkg;

  localparam int unsigned MAX_CLOCKS = 8;

  localparam int unsigned DEF_DIV   = 2;
  localparam int unsigned DEF_PHASE = 0;
  localparam int unsigned DEF_HIGH  = 1;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOCKED = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

endpackage

// File: rtl/lab1_sys_clkgen_chan.sv
// One generated clock: clamped shadow config, active config, phase-loaded
// wrap counter and registered high-time compare.
module lab1_sys_clkgen_chan
  import lab1_sys_clkgen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  input  logic [DIV_W-1:0] wr_high,
  input  logic             reload,
  output logic             clk_out
);

  logic [DIV_W-1:0] sh_div;
  logic [DIV_W-1:0] sh_phase;
  logic [DIV_W-1:0] sh_high;
  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] act_high;
  logic [DIV_W-1:0] cnt;

  logic [DIV_W-1:0] div_c;
  logic [DIV_W-1:0] phase_c;
  logic [DIV_W-1:0] cnt_start;
  logic [DIV_W-1:0] cnt_next;

  // Values are clamped before storage so shadow/active never hold N<2 or phase>=N.
  always_comb begin
    div_c = (wr_div < DIV_W'(2)) ? DIV_W'(2) : wr_div;
    phase_c = (wr_phase >= div_c) ? (div_c - DIV_W'(1)) : wr_phase;
  end

  assign cnt_start = (sh_phase == '0) ? '0 : (sh_div - sh_phase);
  assign cnt_next  = (cnt >= act_div - DIV_W'(1)) ? '0 : (cnt + DIV_W'(1));

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sh_div   <= DIV_W'(DEF_DIV);
      sh_phase <= DIV_W'(DEF_PHASE);
      sh_high  <= DIV_W'(DEF_HIGH);
      act_div  <= DIV_W'(DEF_DIV);
      act_high <= DIV_W'(DEF_HIGH);
      cnt      <= '0;
      clk_out  <= 1'b0;
    end else begin
      if (wr_en) begin
        sh_div   <= div_c;
        sh_phase <= phase_c;
        sh_high  <= wr_high;
      end
      if (reload) begin
        act_div  <= sh_div;
        act_high <= sh_high;
        cnt      <= cnt_start;
      end else begin
        cnt <= cnt_next;
      end
      clk_out <= (cnt < act_high);
    end
  end

endmodule

// File: rtl/lab1_sys_clkgen.sv
// Multi-channel divided clock generator with shadow/active config,
// synchronous restart on apply and a settle timer driving locked.
//
// state     | meaning
// ST_SETTLE | channels running, counting LOCK_CYCLES before locked
// ST_LOCKED | locked=1, waiting for cfg_apply
// ST_RELOAD | one cycle: shadow->active, counters restarted, cfg_ready=0
module lab1_sys_clkgen
  import lab1_sys_clkgen_pkg::*;
#(
  parameter int NUM_CLOCKS  = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  input  logic [DIV_W-1:0]      cfg_high,
  input  logic                  cfg_apply,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  if (NUM_CLOCKS < 1 || NUM_CLOCKS > MAX_CLOCKS) begin : g_bad_num_clocks
    $error("NUM_CLOCKS out of range");
  end

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             reload;
  logic             wr_fire;

  assign reload  = (state == ST_RELOAD);
  assign wr_fire = cfg_valid && cfg_ready;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (cfg_apply) begin
            state      <= ST_RELOAD;
            settle_cnt <= '0;
            locked     <= 1'b0;
            cfg_ready  <= 1'b0;
          end else if (settle_cnt == CNT_LAST) begin
            state     <= ST_LOCKED;
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
            locked     <= 1'b0;
            cfg_ready  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (cfg_apply) begin
            state     <= ST_RELOAD;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
          end else begin
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
          end
        end
        ST_RELOAD: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
          locked     <= 1'b0;
          cfg_ready  <= 1'b1;
        end
        default: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
          locked     <= 1'b0;
          cfg_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Writes to channel indices without a generated channel match nothing and are dropped.
  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    lab1_sys_clkgen_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .refclk  (refclk),
      .rst     (rst),
      .wr_en   (wr_fire && (cfg_chan == 3'(i))),
      .wr_div  (cfg_div),
      .wr_phase(cfg_phase),
      .wr_high (cfg_high),
      .reload  (reload),
      .clk_out (outclk[i])
    );
  end

endmodule

// File: tb/tb_lab1_sys_clkgen.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge
// monitor pops and compares them against the generated clocks and status.
module tb_lab1_sys_clkgen;

  localparam int NUM_CLOCKS  = 2;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 16;

  logic                  refclk = 1'b0;
  logic                  rst;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [2:0]            cfg_chan;
  logic [DIV_W-1:0]      cfg_div;
  logic [DIV_W-1:0]      cfg_phase;
  logic [DIV_W-1:0]      cfg_high;
  logic                  cfg_apply;
  logic [NUM_CLOCKS-1:0] outclk;
  logic                  locked;

  lab1_sys_clkgen #(
    .NUM_CLOCKS (NUM_CLOCKS),
    .DIV_W      (DIV_W),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .cfg_high (cfg_high),
    .cfg_apply(cfg_apply),
    .outclk   (outclk),
    .locked   (locked)
  );

  initial forever #5 refclk = ~refclk;

  typedef struct {
    int         cyc;
    logic [1:0] oc;
    bit         oc_chk;
    logic       lk;
    logic       rdy;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  initial forever begin
    @(posedge refclk);
    cyc++;
  end

  // Hand-derived waveforms, j = cycles since the first edge after counter load.
  // sc0: both N=2 h=1 p=0; sc1: ch0 N4 h2 p0, ch1 N4 h2 p1;
  // sc2: ch0 N2 h1 p1 (clamped), ch1 as sc1; sc3: ch0 high 0, ch1 as sc1.
  function automatic logic [1:0] exp_oc(int sc, int j);
    logic b0;
    logic b1;
    b1 = (((j + 3) % 4) < 2);
    case (sc)
      0: begin b0 = (j % 2 == 0); b1 = b0; end
      1: b0 = ((j % 4) < 2);
      2: b0 = (j % 2 == 1);
      default: b0 = 1'b0;
    endcase
    return {b1, b0};
  endfunction

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic push(int c, logic [1:0] oc, bit chk, logic lk, logic rdy, string tag);
    exp_t e;
    e.cyc = c; e.oc = oc; e.oc_chk = chk; e.lk = lk; e.rdy = rdy; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_run(int origin, int k0, int k1, int sc, int lock_k, string tag);
    for (int k = k0; k <= k1; k++)
      push(k, exp_oc(sc, k - origin), 1'b1, (k >= lock_k), 1'b1, tag);
  endtask

  task automatic cfg_write(logic [2:0] ch, int dv, int ph, int hi);
    cfg_valid = 1'b1;
    cfg_chan  = ch;
    cfg_div   = DIV_W'(dv);
    cfg_phase = DIV_W'(ph);
    cfg_high  = DIV_W'(hi);
    step();
    cfg_valid = 1'b0;
  endtask

  // RELOAD on edge p+1, counters loaded on edge p+2, locked 16 edges later.
  task automatic apply_run(int sc, int len, string tag);
    int p;
    p = cyc;
    cfg_apply = 1'b1;
    push(p + 1, 2'b00, 1'b0, 1'b0, 1'b0, {tag, "_reload"});
    push(p + 2, 2'b00, 1'b0, 1'b0, 1'b1, {tag, "_load"});
    push_run(p + 3, p + 3, p + 2 + len, sc, p + 2 + LOCK_CYCLES, tag);
    step();
    cfg_apply = 1'b0;
    cfg_valid = 1'b0;
    repeat (len + 1) step();
  endtask

  task automatic do_release(string tag);
    int r;
    push(cyc, 2'b00, 1'b1, 1'b0, 1'b0, {tag, "_in_rst"});
    rst = 1'b0;
    r = cyc;
    push_run(r + 1, r + 1, r + 20, 0, r + LOCK_CYCLES, tag);
    repeat (20) step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        if (e.cyc < cyc) begin
          bad++;
          $display("FAIL %s missed: expected at cyc=%0d, now cyc=%0d", e.tag, e.cyc, cyc);
        end else if ((e.oc_chk && outclk !== e.oc) || locked !== e.lk || cfg_ready !== e.rdy) begin
          bad++;
          $display("FAIL %s cyc=%0d outclk got=%b exp=%b(chk=%0d) locked got=%b exp=%b ready got=%b exp=%b",
                   e.tag, cyc, outclk, e.oc, e.oc_chk, locked, e.lk, cfg_ready, e.rdy);
        end
      end
    end
  end

  initial begin : stim
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    cfg_high  = '0;
    cfg_apply = 1'b0;
    repeat (3) step();
    do_release("por");

    // ch1 write in the same cycle as apply must be part of the apply
    cfg_write(3'd0, 4, 0, 2);
    cfg_valid = 1'b1;
    cfg_chan  = 3'd1;
    cfg_div   = DIV_W'(4);
    cfg_phase = DIV_W'(1);
    cfg_high  = DIV_W'(2);
    apply_run(1, 20, "two_ch");

    cfg_write(3'd0, 1, 9, 1);
    apply_run(2, 20, "clamp_phase");

    cfg_write(3'd0, 0, 9, 0);
    apply_run(3, 10, "high0");
    apply_run(3, 20, "mid_settle");

    cfg_write(3'd5, 3, 0, 1);
    apply_run(3, 12, "bad_chan");

    cfg_apply = 1'b1;
    step();
    cfg_apply = 1'b0;
    rst = 1'b1;
    push(cyc, 2'b00, 1'b1, 1'b0, 1'b0, "rst_in_reload");
    step();
    push(cyc, 2'b00, 1'b1, 1'b0, 1'b0, "rst_hold");
    step();
    do_release("post_rst");
    apply_run(0, 8, "shadow_cleared");

    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lab1_sys_clkgen.md
LAB1_SYS_CLKGEN -- requirements
Module: lab1_sys_clkgen

Interface
REQ-001 SHALL have parameter NUM_CLOCKS, default 2, number of generated clock outputs (1..8).
REQ-002 SHALL have parameter DIV_W, default 8, width of divide, phase and high-time fields.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16, refclk cycles from (re)start to locked assertion (>=1).
REQ-004 SHALL provide refclk  input  1  single clock for all logic; one clock, no other clock inputs.
REQ-005 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL provide cfg_valid  input  1  config-write request.
REQ-007 SHALL provide cfg_ready  output  1  config-write accept.
REQ-008 SHALL provide cfg_chan  input  3  target channel index.
REQ-009 SHALL provide cfg_div  input  DIV_W  divide ratio N (period = N refclk cycles).
REQ-010 SHALL provide cfg_phase  input  DIV_W  phase delay in refclk cycles.
REQ-011 SHALL provide cfg_high  input  DIV_W  high time in refclk cycles.
REQ-012 SHALL provide cfg_apply  input  1  pulse: copy shadow config to active and restart all channels.
REQ-013 SHALL provide outclk  output  NUM_CLOCKS  registered generated clocks, bit i = channel i.
REQ-014 SHALL provide locked  output  1  all channels running with active config for LOCK_CYCLES.

Function
REQ-015 SHALL write cfg_div/phase/high into channel cfg_chan shadow registers on the cycle cfg_valid && cfg_ready is high.
REQ-016 SHALL ignore (accept, discard) writes with cfg_chan >= NUM_CLOCKS.
REQ-017 SHALL clamp stored divide: N<2 stored as 2.
REQ-018 SHALL clamp stored phase: phase>=N stored as N-1 (using clamped N).
REQ-019 SHALL run FSM states SETTLE, LOCKED, RELOAD; SETTLE entered on reset release.
REQ-020 SHALL in SETTLE count refclk cycles from 0; on count==LOCK_CYCLES-1 go to LOCKED next cycle.
REQ-021 SHALL in LOCKED hold locked=1; on cfg_apply go to RELOAD.
REQ-022 SHALL treat cfg_apply in SETTLE as going to RELOAD (settle count discarded).
REQ-023 SHALL in RELOAD (exactly one cycle) copy all shadows to active, load every channel counter, deassert locked, then enter SETTLE.
REQ-024 SHALL hold cfg_ready=0 only in RELOAD; cfg_valid in the same cycle as cfg_apply SHALL be written to shadow first, so it is included in the apply.
REQ-025 SHALL per channel run counter c over 0..N-1, incrementing each cycle, wrapping N-1 to 0.
REQ-026 SHALL on restart load c = (N - phase) mod N, so all channels with phase 0 rise on the same cycle.
REQ-027 SHALL drive outclk[i] registered: 1 when c < high, else 0; high=0 gives constant 0, high>=N constant 1.
REQ-028 SHALL set locked=0 in all states except LOCKED; locked SHALL be registered.
REQ-029 SHALL have 1-cycle latency from counter value to outclk bit.

Reset
REQ-030 SHALL on rst force outclk=0, locked=0, cfg_ready=0, FSM=SETTLE, settle count=0, asynchronously.
REQ-031 SHALL on rst load shadow and active of every channel to N=2, phase=0, high=1, counters=0.
REQ-032 SHALL drive cfg_ready=1 from the first refclk edge after rst deasserts.
REQ-033 SHALL treat rst asserted mid-RELOAD or mid-SETTLE identically to power-on reset; no shadow state survives.

Structure
REQ-034 SHALL place FSM state encoding, reset defaults (N=2, phase 0, high 1) and MAX_CLOCKS=8 in shared package lab1_sys_clkgen_pkg.
REQ-035 SHALL implement one channel (counter, clamp-applied active regs, output compare) as sub-module lab1_sys_clkgen_chan, instantiated NUM_CLOCKS times by generate.

Verification
REQ-036 SHALL test reset release, defaults -> outclk both toggle period 2, in phase; locked rises on cycle 16 after release.
REQ-037 SHALL test ch0 N=4 high=2 phase=0, ch1 N=4 high=2 phase=1, apply -> locked drops next cycle, ch1 rises 1 cycle after ch0, locked back after 16 cycles.
REQ-038 SHALL test cfg_div=0, cfg_phase=9, high=0 on ch0 then apply -> N=2, phase=1, outclk[0] constant 0.
REQ-039 SHALL test cfg_apply at settle count 10 -> RELOAD, locked stays 0, settle restarts, locked after 16 further cycles.
REQ-040 SHALL test cfg_valid with cfg_chan=5 (NUM_CLOCKS=2) then apply -> outputs unchanged in period and duty.
REQ-041 SHALL test rst asserted during RELOAD -> outclk=0, locked=0 immediately; defaults restored after release.
